// File: rtl/alu181_serial.sv
// rtl/alu181_serial.sv - slice-serial 74181-style ALU behind valid/ready ports
// Optional zero/ovf flag outputs are enabled by defining ALU181_SERIAL_FLAGS_EN.
module alu181_serial #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             aeqb
`ifdef ALU181_SERIAL_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    generate
        if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_width
            $error("alu181_serial: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [3:0]       s_q;
    logic             m_q;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] x_sl;
    logic [SLICE-1:0] y_sl;
    logic [SLICE-1:0] res_sl;
    logic [SLICE:0]   sum_sl;
    logic [WIDTH-1:0] acc_next;
    logic             carry_next;
    logic             last;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Operands are shifted right each slice, so the current slice is always the low bits.
    always_comb begin
        a_sl       = a_q[SLICE-1:0];
        b_sl       = b_q[SLICE-1:0];
        x_sl       = a_sl | (b_sl & {SLICE{s_q[0]}}) | (~b_sl & {SLICE{s_q[1]}});
        y_sl       = a_sl & ((b_sl & {SLICE{s_q[3]}}) | (~b_sl & {SLICE{s_q[2]}}));
        sum_sl     = {1'b0, x_sl} + {1'b0, y_sl} + {{SLICE{1'b0}}, carry};
        res_sl     = m_q ? ~(x_sl ^ y_sl) : sum_sl[SLICE-1:0];
        carry_next = ~m_q & sum_sl[SLICE];
        last       = (cnt == CW'(NSLICE - 1));
    end

    // Result slices enter at the top of the accumulator and walk down to their place.
    generate
        if (NSLICE > 1) begin : g_multi
            assign acc_next = {res_sl, acc[WIDTH-1:SLICE]};
        end else begin : g_single
            assign acc_next = res_sl;
        end
    endgenerate

`ifdef ALU181_SERIAL_FLAGS_EN
    logic msb_cin;
    assign msb_cin = sum_sl[SLICE-1] ^ x_sl[SLICE-1] ^ y_sl[SLICE-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            acc   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            m_q   <= 1'b0;
            f     <= '0;
            cout  <= 1'b0;
            aeqb  <= 1'b0;
`ifdef ALU181_SERIAL_FLAGS_EN
            zero  <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        s_q   <= s;
                        m_q   <= m;
                        carry <= ~m & cin;
                        cnt   <= '0;
                        acc   <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    a_q   <= a_q >> SLICE;
                    b_q   <= b_q >> SLICE;
                    acc   <= acc_next;
                    carry <= carry_next;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        f     <= acc_next;
                        cout  <= carry_next;
                        aeqb  <= &acc_next;
`ifdef ALU181_SERIAL_FLAGS_EN
                        zero  <= ~|acc_next;
                        ovf   <= ~m_q & (msb_cin ^ sum_sl[SLICE]);
`endif
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu181_serial.sv
// tb/tb_alu181_serial.sv - directed self-checking bench for alu181_serial
module tb_alu181_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic        m;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] f;
    logic        cout;
    logic        aeqb;
`ifdef ALU181_SERIAL_FLAGS_EN
    logic        zero;
    logic        ovf;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0] exp_lg [16];

    alu181_serial #(.WIDTH(16), .SLICE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .m         (m),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .cout      (cout),
        .aeqb      (aeqb)
`ifdef ALU181_SERIAL_FLAGS_EN
        ,
        .zero      (zero),
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb, input logic [3:0] ts,
                            input logic tm, input logic tc);
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        a = ta; b = tb; s = ts; m = tm; cin = tc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 4);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                      input logic [3:0] ts, input logic tm, input logic tc,
                      input logic [15:0] ef, input logic ec, input logic eq,
                      input logic ez, input logic eo);
        start_op(ta, tb, ts, tm, tc);
        // scramble ports after the accept edge; they must not matter
        a = ~ta; b = ~tb; s = ~ts; cin = ~tc;
        wait_done(tag);
        check({tag, "_f"}, {16'd0, f}, {16'd0, ef});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, "_aeqb"}, {31'd0, aeqb}, {31'd0, eq});
`ifdef ALU181_SERIAL_FLAGS_EN
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
        if (ez === 1'bx || eo === 1'bx) $display("bad flag expectation in %s", tag);
`endif
        handshake(tag);
    endtask

    initial begin
        bit seen_valid;

        exp_lg = '{16'hFFFC, 16'hFFF8, 16'h0004, 16'h0000,
                   16'hFFFD, 16'hFFF9, 16'h0005, 16'h0001,
                   16'hFFFE, 16'hFFFA, 16'h0006, 16'h0002,
                   16'hFFFF, 16'hFFFB, 16'h0007, 16'h0003};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; s = '0; m = 1'b0; cin = 1'b0;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_f", {16'd0, f}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_aeqb", {31'd0, aeqb}, 32'd0);
`ifdef ALU181_SERIAL_FLAGS_EN
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // arithmetic vectors
        op("add_3_6",      16'h0003, 16'h0006, 4'b1001, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0);
        op("add_ffff_1",   16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        op("add_7fff_1",   16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1);
        op("sub_eq",       16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        op("sub_6_3_cin",  16'h0006, 16'h0003, 4'b0110, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0);
        op("minus_one",    16'h5A5A, 16'h0F0F, 4'b0011, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        op("a_plus_a",     16'h4321, 16'h0000, 4'b1100, 1'b0, 1'b0, 16'h8642, 1'b0, 1'b0, 1'b0, 1'b1);

        // logic sweep, cin driven high to show it is ignored
        for (int i = 0; i < 16; i++) begin
            op($sformatf("logic_s%0d", i), 16'h0003, 16'h0006, i[3:0], 1'b1, 1'b1,
               exp_lg[i], 1'b0, exp_lg[i] == 16'hFFFF, exp_lg[i] == 16'h0000, 1'b0);
        end

        // backpressure: result held, requests refused
        start_op(16'h0003, 16'h0006, 4'b1001, 1'b0, 1'b0);
        wait_done("bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom);
            tick();
            check("bp_f_stable", {16'd0, f}, 32'h0009);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        handshake("bp");
        check("bp_f_retained", {16'd0, f}, 32'h0009);
        tick();
        check("bp_no_second_accept", {31'd0, out_valid | ~in_ready}, 32'd0);

        // reset during the second busy cycle
        start_op(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_f", {16'd0, f}, 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        check("abort_no_result", {31'd0, seen_valid}, 32'd0);
        op("after_abort",  16'h0003, 16'h0006, 4'b1001, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
